seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
Time-multiplexed driver for NDIGITS common-electrode 7-segment digits plus decimal points. Scans one digit per slot, decodes its 4-bit hex value to segments and drives one shared 8-bit segment bus with a one-hot digit select. Sits between a CPU-writable display register and the board LED pins. It is the scanned, registered successor of the combinational single-digit decoder.

Parameters:
NDIGITS, 4, number of digits scanned (2..8)
SLOT_CYCLES, 1024, clk cycles per digit slot (>= 4)
GUARD_CYCLES, 2, cycles at start of each slot with all outputs off (anti-ghosting; < SLOT_CYCLES)
SEG_ACTIVE_LOW, 0, 1 = invert leds bus at the pins
DIG_ACTIVE_LOW, 0, 1 = invert digit_sel at the pins

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
oe  in  1  display enable; 0 forces all segments and digits inactive
load  in  1  one-cycle strobe: capture data/dots into shadow register
data  in  4*NDIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost
dots  in  NDIGITS  decimal point per digit
leds  out  8  {dp,g,f,e,d,c,b,a} for active digit, registered
digit_sel  out  NDIGITS  one-hot active digit, registered
frame_tick  out  1  one-cycle pulse when scan wraps to digit 0

Behaviour:
- Reset: leds=0, digit_sel=0, frame_tick=0 (logical levels before polarity inversion); slot counter=0, digit index=0; shadow and display registers = 0.
- Shadow: load=1 captures data/dots into shadow on that edge. Shadow copies into display register only at the frame boundary (slot counter wraps on digit NDIGITS-1) -> no torn frames. load coinciding with the boundary: display gets the OLD shadow, new value appears next frame.
- Slot counter 0..SLOT_CYCLES-1; at SLOT_CYCLES-1 wraps to 0 and digit index increments; index NDIGITS-1 wraps to 0 and frame_tick pulses on that same edge.
- Outputs registered, 1 cycle after counter/index state. During counter < GUARD_CYCLES: leds=0, digit_sel=0. Otherwise digit_sel = 1<<index, leds = {dot[index], seg(nibble[index])}.
- seg table (g..a, hex): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71.
- oe=0: leds=0, digit_sel=0 from next edge; scan counters and frame_tick keep running, load still accepted. oe re-asserted: resumes at current slot, no restart.
- Polarity: inversion applied after registered value; reset shows inactive pin level (all ones when active-low).
- rst mid-scan: next edge returns to reset state regardless of load/oe.
- Never more than one digit_sel bit active.

Optional Feature:
LEADING_ZERO_BLANK_EN. Defined: adds input lzb (1 bit). When lzb=1, any digit i whose nibble is 0 and all higher digits are 0 shows leds={dot[i],7'h00}; digit 0 is never blanked (value 0 displays "0"). Evaluated on the display register. Not defined: port absent, all digits decoded normally.

Test Plan:
- NDIGITS=4, SLOT_CYCLES=8, GUARD=2: rst, oe=1, load data=16'h1A2F, dots=4'b0100 -> after first frame boundary slots show digit_sel 0001/0010/0100/1000 with leds 71,5B,F7,06; guard cycles all 0; frame_tick once per 32 cycles.
- load data=16'h0000 mid-frame -> outputs unchanged until frame_tick, next frame shows 3F on all digits.
- oe=0 for 20 cycles mid-slot -> leds/digit_sel 0 from next edge; frame_tick period unchanged; oe=1 resumes at the digit the counters indicate.
- SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, data digit=8, dot=1 -> leds pin 8'h00, digit_sel pin active bit 0, others 1; in reset all pins 1.
- rst asserted during slot 2 with load=1 same cycle -> next cycle all outputs 0, display register 0.
- LEADING_ZERO_BLANK_EN, lzb=1, data=16'h0050 -> digits 3,2 leds 00, digit 1 6D, digit 0 3F; lzb=0 -> digits 3,2 show 3F.

Source files
------------

// File: rtl/seg_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_mux_if
// Purpose  : Display-register bus and LED pin group for seg_scan_mux.
//            Optional lzb input present when LEADING_ZERO_BLANK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_mux_if #(
    parameter int NDIGITS = 4
);
    logic                   oe;
    logic                   load;
    logic [4*NDIGITS-1:0]   data;
    logic [NDIGITS-1:0]     dots;
`ifdef LEADING_ZERO_BLANK_EN
    logic                   lzb;
`endif
    logic [7:0]             leds;
    logic [NDIGITS-1:0]     digit_sel;
    logic                   frame_tick;

    modport master (
`ifdef LEADING_ZERO_BLANK_EN
        output lzb,
`endif
        output oe, load, data, dots,
        input  leds, digit_sel, frame_tick
    );

    modport slave (
`ifdef LEADING_ZERO_BLANK_EN
        input  lzb,
`endif
        input  oe, load, data, dots,
        output leds, digit_sel, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_mux
// Purpose  : Scanned, registered 7-segment driver for NDIGITS digits with a
//            frame-synchronous shadow register. Optional: LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_mux #(
    parameter int NDIGITS        = 4,
    parameter int SLOT_CYCLES    = 1024,
    parameter int GUARD_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    seg_scan_mux_if.slave bus
);
    localparam int c_CNT_W = $clog2(SLOT_CYCLES);
    localparam int c_IDX_W = $clog2(NDIGITS);
    localparam logic [c_CNT_W-1:0] c_SLOT_LAST = c_CNT_W'(SLOT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD     = c_CNT_W'(GUARD_CYCLES);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(NDIGITS - 1);
    localparam logic [NDIGITS-1:0] c_SEL_ONE   = {{(NDIGITS-1){1'b0}}, 1'b1};

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [c_CNT_W-1:0]   r_slot_cnt;
    logic [c_IDX_W-1:0]   r_dig_idx;
    logic [4*NDIGITS-1:0] r_shadow_data;
    logic [NDIGITS-1:0]   r_shadow_dots;
    logic [4*NDIGITS-1:0] r_disp_data;
    logic [NDIGITS-1:0]   r_disp_dots;
    logic [7:0]           r_leds;
    logic [NDIGITS-1:0]   r_digit_sel;
    logic                 r_frame_tick;

    logic                 w_slot_last;
    logic                 w_frame_last;
    logic                 w_guard;
    logic [3:0]           w_nibble;
    logic                 w_dot;
    logic                 w_blank;
    logic [7:0]           w_leds_nxt;

    assign w_slot_last  = (r_slot_cnt == c_SLOT_LAST);
    assign w_frame_last = w_slot_last && (r_dig_idx == c_IDX_LAST);
    assign w_guard      = (r_slot_cnt < c_GUARD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_cnt <= '0;
            r_dig_idx  <= '0;
        end else if (w_slot_last) begin
            r_slot_cnt <= '0;
            r_dig_idx  <= (r_dig_idx == c_IDX_LAST) ? '0 : r_dig_idx + 1'b1;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    // Display only changes at the frame boundary, so a frame is never torn;
    // a load on the boundary edge is seen one frame later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_data <= '0;
            r_shadow_dots <= '0;
            r_disp_data   <= '0;
            r_disp_dots   <= '0;
        end else begin
            if (bus.load) begin
                r_shadow_data <= bus.data;
                r_shadow_dots <= bus.dots;
            end
            if (w_frame_last) begin
                r_disp_data <= r_shadow_data;
                r_disp_dots <= r_shadow_dots;
            end
        end
    end

    always_comb begin
        w_nibble = 4'h0;
        w_dot    = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (r_dig_idx == c_IDX_W'(i)) begin
                w_nibble = r_disp_data[4*i +: 4];
                w_dot    = r_disp_dots[i];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_zero_run;

    // Walk from the top digit down: a digit is blankable while it and every
    // digit above it are zero. Digit 0 always displays.
    always_comb begin
        w_blank    = 1'b0;
        w_zero_run = 1'b1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (r_disp_data[4*i +: 4] == 4'h0);
            if ((i != 0) && (r_dig_idx == c_IDX_W'(i)) && w_zero_run) begin
                w_blank = bus.lzb;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    assign w_leds_nxt = {w_dot, (w_blank ? 7'h00 : seg_decode(w_nibble))};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds       <= '0;
            r_digit_sel  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_last;
            if (!bus.oe || w_guard) begin
                r_leds      <= '0;
                r_digit_sel <= '0;
            end else begin
                r_leds      <= w_leds_nxt;
                r_digit_sel <= c_SEL_ONE << r_dig_idx;
            end
        end
    end

    assign bus.leds       = SEG_ACTIVE_LOW ? ~r_leds : r_leds;
    assign bus.digit_sel  = DIG_ACTIVE_LOW ? ~r_digit_sel : r_digit_sel;
    assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_mux
// Purpose  : Directed bench for seg_scan_mux (NDIGITS=4, SLOT=8, GUARD=2),
//            plain-polarity and inverted-polarity instances side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_mux;
    localparam int ND = 4;
    localparam int SC = 8;
    localparam int GC = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    seg_scan_mux_if #(.NDIGITS(ND)) bus_a ();
    seg_scan_mux_if #(.NDIGITS(ND)) bus_b ();

    assign bus_b.oe   = bus_a.oe;
    assign bus_b.load = bus_a.load;
    assign bus_b.data = bus_a.data;
    assign bus_b.dots = bus_a.dots;
`ifdef LEADING_ZERO_BLANK_EN
    assign bus_b.lzb  = bus_a.lzb;
`endif

    seg_scan_mux #(
        .NDIGITS(ND), .SLOT_CYCLES(SC), .GUARD_CYCLES(GC),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    seg_scan_mux #(
        .NDIGITS(ND), .SLOT_CYCLES(SC), .GUARD_CYCLES(GC),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ftick(output int cycles);
        logic found;
        found  = 1'b0;
        cycles = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            cycles++;
            if (bus_a.frame_tick) found = 1'b1;
        end
        chk("wait_ftick", found, 1);
    endtask

    // Runs one 32-cycle frame right after a frame_tick. Step n shows the
    // scan state of step n-1: slot = (n-1)%8, digit = (n-1)/8.
    task automatic run_frame(input string name,
                             input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3,
                             input int ld_step, input logic [15:0] ld_data,
                             input logic [3:0] ld_dots,
                             input int oe_from, input int oe_len);
        logic [7:0] exp_tab [4];
        exp_tab[0] = e0;
        exp_tab[1] = e1;
        exp_tab[2] = e2;
        exp_tab[3] = e3;
        for (int n = 1; n <= SC * ND; n++) begin
            int         cnt;
            int         idx;
            logic       off;
            logic [7:0] el;
            logic [3:0] es;
            logic [7:0] el_n;
            logic [3:0] es_n;
            bus_a.load = (n == ld_step);
            if (n == ld_step) begin
                bus_a.data = ld_data;
                bus_a.dots = ld_dots;
            end
            off = (n >= oe_from) && (n < oe_from + oe_len);
            bus_a.oe = !off;
            tick();
            bus_a.load = 1'b0;
            cnt = (n - 1) % SC;
            idx = (n - 1) / SC;
            if (off || cnt < GC) begin
                el = 8'h00;
                es = 4'h0;
            end else begin
                el = exp_tab[idx];
                es = 4'(1 << idx);
            end
            el_n = ~el;
            es_n = ~es;
            chk($sformatf("%s_n%0d_leds", name, n), bus_a.leds, el);
            chk($sformatf("%s_n%0d_sel", name, n), bus_a.digit_sel, es);
            chk($sformatf("%s_n%0d_ftick", name, n), bus_a.frame_tick, (n == SC * ND));
            chk($sformatf("%s_n%0d_inv_leds", name, n), bus_b.leds, el_n);
            chk($sformatf("%s_n%0d_inv_sel", name, n), bus_b.digit_sel, es_n);
        end
        bus_a.oe = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst        = 1'b1;
        bus_a.oe   = 1'b0;
        bus_a.load = 1'b0;
        bus_a.data = '0;
        bus_a.dots = '0;
`ifdef LEADING_ZERO_BLANK_EN
        bus_a.lzb  = 1'b0;
`endif
        repeat (2) tick();
        chk("rst_leds", bus_a.leds, 8'h00);
        chk("rst_sel", bus_a.digit_sel, 4'h0);
        chk("rst_ftick", bus_a.frame_tick, 1'b0);
        chk("rst_inv_leds", bus_b.leds, 8'hFF);
        chk("rst_inv_sel", bus_b.digit_sel, 4'hF);

        rst        = 1'b0;
        bus_a.oe   = 1'b1;
        bus_a.load = 1'b1;
        bus_a.data = 16'h1A2F;
        bus_a.dots = 4'b0100;
        tick();
        bus_a.load = 1'b0;
        wait_ftick(cyc);

        run_frame("f1", 8'h71, 8'h5B, 8'hF7, 8'h06, 10, 16'h0000, 4'b0000, 0, 0);
        run_frame("f2", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 32, 16'h8765, 4'b1001, 0, 0);
        run_frame("f3", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 0, 16'h0000, 4'b0000, 0, 0);
        run_frame("f4", 8'hED, 8'h7D, 8'h07, 8'hFF, 0, 16'h0000, 4'b0000, 0, 0);
        run_frame("f5oe", 8'hED, 8'h7D, 8'h07, 8'hFF, 0, 16'h0000, 4'b0000, 4, 20);
        run_frame("f6", 8'hED, 8'h7D, 8'h07, 8'hFF, 0, 16'h0000, 4'b0000, 0, 0);

        repeat (19) tick();
        rst        = 1'b1;
        bus_a.load = 1'b1;
        bus_a.data = 16'hFFFF;
        bus_a.dots = 4'hF;
        tick();
        rst        = 1'b0;
        bus_a.load = 1'b0;
        chk("mrst_leds", bus_a.leds, 8'h00);
        chk("mrst_sel", bus_a.digit_sel, 4'h0);
        chk("mrst_ftick", bus_a.frame_tick, 1'b0);
        chk("mrst_inv_leds", bus_b.leds, 8'hFF);
        chk("mrst_inv_sel", bus_b.digit_sel, 4'hF);
        wait_ftick(cyc);
        chk("mrst_realign", cyc, 32);
        run_frame("f7", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 0, 16'h0000, 4'b0000, 0, 0);

`ifdef LEADING_ZERO_BLANK_EN
        bus_a.lzb = 1'b1;
        run_frame("f8lzb", 8'h3F, 8'h00, 8'h00, 8'h00, 10, 16'h0050, 4'b0000, 0, 0);
        run_frame("f9lzb", 8'h3F, 8'h6D, 8'h00, 8'h00, 0, 16'h0000, 4'b0000, 0, 0);
        bus_a.lzb = 1'b0;
        run_frame("f10lzb", 8'h3F, 8'h6D, 8'h3F, 8'h3F, 0, 16'h0000, 4'b0000, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
